// File: rtl/motion_compensation.sv
// Motion compensation: fetches a motion-shifted macroblock from the search window,
// subtracts it from the current macroblock and streams residuals behind a 2-entry buffer.
module motion_compensation #(
    parameter int MB_SIZE       = 16,
    parameter int SEARCH_WINDOW = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mv_valid,
    output logic        mv_ready,
    input  logic [7:0]  mv_x,
    input  logic [7:0]  mv_y,
    output logic [12:0] ref_addr,
    input  logic [7:0]  ref_data,
    output logic [7:0]  cur_addr,
    input  logic [7:0]  cur_data,
    output logic        rd_en,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [8:0]  res_data,
    output logic        res_last
);
    localparam int WIN  = MB_SIZE + SEARCH_WINDOW;
    localparam int HALF = SEARCH_WINDOW / 2;
    localparam int OW   = $clog2(SEARCH_WINDOW + 1);
    localparam int CW   = $clog2(MB_SIZE);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [OW-1:0] x0, y0;
    logic [CW-1:0] row, col;
    logic          pipe_vld, pipe_last;
    logic [8:0]    fifo_data [2];
    logic          fifo_last [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    fifo_cnt;

    logic          last_rd, fifo_empty, push, pop, hs_last;
    logic [8:0]    diff, out_data;
    logic          out_last;

    // Clamp the vector to the search range and convert it to a window origin.
    function automatic logic [OW-1:0] origin(input logic [7:0] mv);
        int v;
        v = int'($signed(mv));
        if (v > HALF)
            v = HALF;
        else if (v < -HALF)
            v = -HALF;
        return OW'(v + HALF);
    endfunction

    assign last_rd    = (row == CW'(MB_SIZE - 1)) && (col == CW'(MB_SIZE - 1));
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign diff       = {1'b0, cur_data} - {1'b0, ref_data};

    // Credit check: buffered samples plus the read still in the RAM must leave room.
    assign rd_en = !rst && (state == RUN) && ((fifo_cnt + {1'b0, pipe_vld}) < 2'd2);

    always_comb begin
        ref_addr = '0;
        cur_addr = '0;
        if (rd_en) begin
            ref_addr = (13'(y0) + 13'(row)) * 13'(WIN) + 13'(x0) + 13'(col);
            cur_addr = 8'(row) * 8'(MB_SIZE) + 8'(col);
        end
    end

    // When the buffer is empty the returning RAM data is presented directly so the
    // first residual appears the cycle the RAMs answer; stalls capture it into the buffer.
    always_comb begin
        out_data = diff;
        out_last = pipe_last;
        if (!fifo_empty) begin
            out_data = fifo_data[rd_ptr];
            out_last = fifo_last[rd_ptr];
        end
    end

    assign res_valid = !rst && (!fifo_empty || pipe_vld);
    assign res_data  = res_valid ? out_data : '0;
    assign res_last  = res_valid && out_last;

    assign push    = pipe_vld && !(fifo_empty && res_ready);
    assign pop     = !fifo_empty && res_ready;
    assign hs_last = res_valid && res_ready && res_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mv_ready  <= 1'b1;
            x0        <= '0;
            y0        <= '0;
            row       <= '0;
            col       <= '0;
            pipe_vld  <= 1'b0;
            pipe_last <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            pipe_vld  <= rd_en;
            pipe_last <= rd_en && last_rd;
            if (push) begin
                fifo_data[wr_ptr] <= diff;
                fifo_last[wr_ptr] <= pipe_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (mv_valid && mv_ready) begin
                        state    <= RUN;
                        mv_ready <= 1'b0;
                        x0       <= origin(mv_x);
                        y0       <= origin(mv_y);
                        row      <= '0;
                        col      <= '0;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        if (col == CW'(MB_SIZE - 1)) begin
                            col <= '0;
                            row <= (row == CW'(MB_SIZE - 1)) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_rd)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs_last) begin
                        state    <= IDLE;
                        mv_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mv_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_motion_compensation.sv
// Scoreboard bench for motion_compensation: a reference model queues expected residuals
// per block and a negedge monitor compares every handshaked sample.
module tb_motion_compensation;
    localparam int MB  = 16;
    localparam int SW  = 64;
    localparam int WIN = MB + SW;

    logic        clk = 1'b0;
    logic        rst, mv_valid, mv_ready, rd_en, res_valid, res_ready, res_last;
    logic [7:0]  mv_x, mv_y, cur_addr;
    logic [7:0]  ref_data = 8'd0;
    logic [7:0]  cur_data = 8'd0;
    logic [12:0] ref_addr;
    logic [8:0]  res_data;

    always #5 clk = ~clk;

    motion_compensation #(.MB_SIZE(MB), .SEARCH_WINDOW(SW)) dut (
        .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .mv_x(mv_x), .mv_y(mv_y), .ref_addr(ref_addr), .ref_data(ref_data),
        .cur_addr(cur_addr), .cur_data(cur_data), .rd_en(rd_en),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last)
    );

    logic [7:0] ref_mem [WIN*WIN];
    logic [7:0] cur_mem [MB*MB];

    always @(posedge clk) begin
        if (rd_en) begin
            ref_data <= ref_mem[ref_addr];
            cur_data <= cur_mem[cur_addr];
        end
    end

    typedef struct {int data; bit last;} exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   samples = 0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int clampv(input int v);
        if (v > SW/2) return SW/2;
        if (v < -SW/2) return -SW/2;
        return v;
    endfunction

    // Reference model: residual(r,c) = cur(c,r) - ref(x0+c, y0+r) from the clamped vector.
    task automatic push_block(input int mx, input int my, output int first_addr);
        int x0, y0;
        exp_t e;
        x0 = clampv(mx) + SW/2;
        y0 = clampv(my) + SW/2;
        for (int r = 0; r < MB; r++)
            for (int c = 0; c < MB; c++) begin
                e.data = int'(cur_mem[r*MB + c]) - int'(ref_mem[(y0 + r)*WIN + x0 + c]);
                e.last = (r == MB-1) && (c == MB-1);
                exp_q.push_back(e);
            end
        first_addr = y0*WIN + x0;
    endtask

    // kinds: ref 0=const 1=x+y 2=x^y 3=random; cur 0=const 1=random
    task automatic fill(input int rk, input int rv, input int ck, input int cv);
        for (int y = 0; y < WIN; y++)
            for (int x = 0; x < WIN; x++)
                case (rk)
                    0: ref_mem[y*WIN + x] = 8'(rv);
                    1: ref_mem[y*WIN + x] = 8'(x + y);
                    2: ref_mem[y*WIN + x] = 8'(x ^ y);
                    default: ref_mem[y*WIN + x] = 8'($urandom);
                endcase
        for (int i = 0; i < MB*MB; i++)
            cur_mem[i] = (ck == 0) ? 8'(cv) : 8'($urandom);
    endtask

    task automatic start_block(input int mx, input int my);
        int fa;
        int n;
        n = 0;
        @(negedge clk);
        while (!mv_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mv_ready_wait", int'(mv_ready), 1);
        push_block(mx, my, fa);
        mv_valid = 1'b1;
        mv_x = 8'(mx);
        mv_y = 8'(my);
        @(posedge clk);
        #1 mv_valid = 1'b0;
        chk("first_rd_en", int'(rd_en), 1);
        chk("first_ref_addr", int'(ref_addr), fa);
        chk("first_cur_addr", int'(cur_addr), 0);
        @(posedge clk);
        #1 chk("first_res_valid_latency", int'(res_valid), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !mv_ready) && n < 5000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("block_done_queue_empty", exp_q.size(), 0);
        chk("block_done_mv_ready", int'(mv_ready), 1);
        chk("block_done_res_valid", int'(res_valid), 0);
    endtask

    // Monitor: compare each handshaked sample; verify held outputs while stalled.
    initial begin
        bit         stalled;
        logic [8:0] sd;
        logic       sl;
        exp_t       e;
        stalled = 1'b0;
        sd = '0;
        sl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    chk("stall_hold", int'(res_valid && res_data == sd && res_last == sl), 1);
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_sample_queue", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", int'($signed(res_data)), e.data);
                        chk("res_last", int'(res_last), int'(e.last));
                    end
                    samples++;
                end
                stalled = res_valid && !res_ready;
                sd = res_data;
                sl = res_last;
            end
        end
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int n, base, mx, my;
        logic signed [7:0] t;
        rst = 1'b1;
        mv_valid = 1'b0;
        mv_x = 8'd0;
        mv_y = 8'd0;
        fill(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mv_ready", int'(mv_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_res_last", int'(res_last), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_ref_addr", int'(ref_addr), 0);
        rst = 1'b0;

        // Constant window, vector (0,0): 256 back-to-back +16 samples.
        fill(0, 8'h80, 0, 8'h90);
        start_block(0, 0);
        n = 1;
        repeat (MB*MB - 1) begin
            @(posedge clk);
            #1 if (res_valid) n++;
        end
        chk("contiguous_samples", n, MB*MB);
        @(posedge clk);
        #1;
        chk("idle_after_last_mv_ready", int'(mv_ready), 1);
        chk("idle_after_last_res_valid", int'(res_valid), 0);
        wait_done();

        // Corner vector and extreme residuals.
        fill(1, 0, 0, 0);
        start_block(-32, 32);
        wait_done();
        fill(0, 0, 0, 255);
        start_block(5, -7);
        wait_done();
        fill(0, 255, 0, 0);
        start_block(-3, 11);
        wait_done();

        // Out-of-range vector must match its clamped equivalent.
        fill(3, 0, 1, 0);
        start_block(40, -100);
        wait_done();
        start_block(32, -32);
        wait_done();

        // Random backpressure, random vectors, stray mv_valid while busy.
        rand_ready = 1'b1;
        fill(2, 0, 1, 0);
        for (int b = 0; b < 4; b++) begin
            t = 8'($urandom);
            mx = int'(t);
            t = 8'($urandom);
            my = int'(t);
            start_block(mx, my);
            mv_valid = 1'b1;
            mv_x = 8'($urandom);
            mv_y = 8'($urandom);
            repeat (10) @(posedge clk);
            #1 mv_valid = 1'b0;
            wait_done();
        end
        rand_ready = 1'b0;

        // Abort mid-block, then a clean block must follow.
        fill(3, 0, 1, 0);
        base = samples;
        start_block(7, -9);
        n = 0;
        while (samples < base + 100 && n < 1000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("abort_reached_100", int'(samples >= base + 100), 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_mv_ready", int'(mv_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("post_abort_res_valid", int'(res_valid), 0);
        fill(3, 0, 1, 0);
        start_block(0, 0);
        wait_done();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
